// File: rtl/uart_tx_param.sv
// Buffered UART transmitter with configurable data bits, parity and stop bits.
// A small FIFO lets the host queue words; queued frames leave back-to-back.
module uart_tx_param #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_tx_dv,
  input  logic [DATA_BITS-1:0]        i_tx_byte,
  output logic                        o_tx_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic                        o_tx_active,
  output logic                        o_tx_serial,
  output logic                        o_tx_done
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = AW + 1;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam bit             HAS_PARITY = (PARITY == 1) || (PARITY == 2);
  localparam logic [NW-1:0]  FULL       = NW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  LAST_CLK   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  DONE_CLK   = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0]  LAST_BIT   = BW'(DATA_BITS - 1);
  localparam logic           LAST_STOP  = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  state_t               state, state_next;
  logic [CW-1:0]        clk_cnt, clk_next;
  logic [BW-1:0]        bit_idx, bit_next;
  logic                 stop_idx, stop_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 par_bit, par_next;
  logic                 serial_next, active_next, done_next;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [NW-1:0]        count_next;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;
  logic                 push, pop, fifo_empty;

  assign push       = i_tx_dv && o_tx_ready;
  assign fifo_empty = (o_fifo_count == '0);
  assign head       = mem[rd_ptr];
  assign head_par   = (PARITY == 1) ? ~(^head) : (^head);

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_tx_byte;
  end

  // Occupancy; a push while full is dropped regardless of a same-cycle pop.
  always_comb begin
    count_next = o_fifo_count;
    if (push && !pop)      count_next = o_fifo_count + 1'b1;
    else if (!push && pop) count_next = o_fifo_count - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fifo_count <= '0;
      o_tx_ready   <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      o_fifo_count <= count_next;
      o_tx_ready   <= (count_next != FULL);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      shift       <= '0;
      par_bit     <= 1'b0;
      o_tx_serial <= 1'b1;
      o_tx_active <= 1'b0;
      o_tx_done   <= 1'b0;
    end else begin
      state       <= state_next;
      clk_cnt     <= clk_next;
      bit_idx     <= bit_next;
      stop_idx    <= stop_next;
      shift       <= shift_next;
      par_bit     <= par_next;
      o_tx_serial <= serial_next;
      o_tx_active <= active_next;
      o_tx_done   <= done_next;
    end
  end

  // Next state; serial/done are computed one cycle early so they register on time.
  always_comb begin
    state_next  = state;
    clk_next    = clk_cnt;
    bit_next    = bit_idx;
    stop_next   = stop_idx;
    shift_next  = shift;
    par_next    = par_bit;
    serial_next = 1'b1;
    done_next   = 1'b0;
    pop         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          shift_next  = head;
          par_next    = head_par;
          clk_next    = '0;
          serial_next = 1'b0;
          state_next  = ST_START;
        end
      end
      ST_START: begin
        serial_next = 1'b0;
        if (clk_cnt == LAST_CLK) begin
          clk_next    = '0;
          bit_next    = '0;
          serial_next = shift[0];
          state_next  = ST_DATA;
        end else begin
          clk_next = clk_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        serial_next = shift[0];
        if (clk_cnt == LAST_CLK) begin
          clk_next = '0;
          if (bit_idx == LAST_BIT) begin
            if (HAS_PARITY) begin
              serial_next = par_bit;
              state_next  = ST_PARITY;
            end else begin
              serial_next = 1'b1;
              stop_next   = 1'b0;
              state_next  = ST_STOP;
            end
          end else begin
            bit_next    = bit_idx + 1'b1;
            shift_next  = shift >> 1;
            serial_next = shift_next[0];
          end
        end else begin
          clk_next = clk_cnt + 1'b1;
        end
      end
      ST_PARITY: begin
        serial_next = par_bit;
        if (clk_cnt == LAST_CLK) begin
          clk_next    = '0;
          stop_next   = 1'b0;
          serial_next = 1'b1;
          state_next  = ST_STOP;
        end else begin
          clk_next = clk_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (clk_cnt == DONE_CLK && stop_idx == LAST_STOP) done_next = 1'b1;
        if (clk_cnt == LAST_CLK) begin
          clk_next = '0;
          if (stop_idx != LAST_STOP) begin
            stop_next = stop_idx + 1'b1;
          end else if (!fifo_empty) begin
            pop         = 1'b1;
            shift_next  = head;
            par_next    = head_par;
            serial_next = 1'b0;
            state_next  = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          clk_next = clk_cnt + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    active_next = (state_next != ST_IDLE);
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: 8N1 main instance plus 7E2/7O2 instances.
module tb_uart_tx_param;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dv;
  logic [7:0] tx_word;
  logic       ready, active, serial, done;
  logic [2:0] count;

  logic       dv7;
  logic [6:0] byte7;
  logic       ready_e, active_e, serial_e, done_e;
  logic       ready_o, active_o, serial_o, done_o;
  logic [2:0] count_e, count_o;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0]  sb[$];
  logic [63:0] sb7[$];
  int          gaps[$];
  int          gap = 1000;
  bit          busy = 1'b0;
  int          done_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_dv(dv), .i_tx_byte(tx_word), .o_tx_ready(ready),
    .o_fifo_count(count), .o_tx_active(active), .o_tx_serial(serial), .o_tx_done(done));

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_even (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_dv(dv7), .i_tx_byte(byte7), .o_tx_ready(ready_e),
    .o_fifo_count(count_e), .o_tx_active(active_e), .o_tx_serial(serial_e), .o_tx_done(done_e));

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_odd (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_dv(dv7), .i_tx_byte(byte7), .o_tx_ready(ready_o),
    .o_fifo_count(count_o), .o_tx_active(active_o), .o_tx_serial(serial_o), .o_tx_done(done_o));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for every cycle of one frame, bit 0 = first cycle.
  function automatic logic [63:0] frame_line(input logic [8:0] d, input int nb,
                                             input int par, input int stops);
    logic [63:0] v = '0;
    logic [15:0] bits = '0;
    int          nbits = 1;
    logic        p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      bits[nbits] = d[i];
      p = p ^ d[i];
      nbits++;
    end
    if (par == 1 || par == 2) begin
      bits[nbits] = (par == 1) ? ~p : p;
      nbits++;
    end
    for (int s = 0; s < stops; s++) begin
      bits[nbits] = 1'b1;
      nbits++;
    end
    for (int b = 0; b < nbits; b++)
      for (int c = 0; c < CPB; c++) v[b*CPB + c] = bits[b];
    return v;
  endfunction

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Captures each 8N1 frame of the main instance and compares against the scoreboard.
  initial begin : monitor
    logic [63:0] ln, ac, dn;
    logic [7:0]  w;
    bit          ab;
    forever begin
      @(negedge clk);
      if (!rst_n) gap = 1000;
      else if (serial === 1'b0) begin
        busy = 1'b1;
        gaps.push_back(gap);
        gap = 0;
        ab = 1'b0;
        ln = '0; ac = '0; dn = '0;
        ln[0] = serial; ac[0] = active; dn[0] = done;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          if (!rst_n) ab = 1'b1;
          ln[i] = serial; ac[i] = active; dn[i] = done;
        end
        if (!ab) begin
          check("frame_expected", 64'(sb.size() != 0), 64'(1));
          if (sb.size() != 0) begin
            w = sb.pop_front();
            check("line", ln, frame_line(9'(w), 8, 0, 1));
            check("done_pos", dn, 64'd1 << 39);
            check("active_win", ac, (64'd1 << 40) - 64'd1);
          end
        end
        busy = 1'b0;
      end else gap++;
    end
  end

  task automatic push(input logic [7:0] w, input bit acc);
    @(negedge clk);
    check("ready", 64'(ready), 64'(acc));
    dv = 1'b1;
    tx_word = w;
    if (acc) sb.push_back(w);
    @(posedge clk);
    #1 dv = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(n < budget), 64'(1));
    @(negedge clk);
  endtask

  initial begin : stim
    int d0, n;
    logic [63:0] ln_e, ln_o, dn_e;
    bit low;
    rst_n = 1'b0; dv = 1'b0; tx_word = '0; dv7 = 1'b0; byte7 = '0;
    repeat (3) @(negedge clk);
    check("rst_serial", 64'(serial), 64'(1));
    check("rst_active", 64'(active), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_ready", 64'(ready), 64'(1));
    check("rst_count", 64'(count), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single 8N1 word: latency and frame shape
    d0 = done_cnt;
    push(8'h37, 1'b1);
    @(negedge clk); check("lat_idle", 64'(serial), 64'(1));
    @(negedge clk); check("lat_start", 64'(serial), 64'(0));
    wait_idle(200);
    check("active_off", 64'(active), 64'(0));
    check("done_once", 64'(done_cnt - d0), 64'(1));

    // 7-bit data with even and odd parity, two stop bits
    @(negedge clk);
    dv7 = 1'b1; byte7 = 7'h55;
    sb7.push_back(frame_line(9'h055, 7, 2, 2));
    sb7.push_back(frame_line(9'h055, 7, 1, 2));
    @(posedge clk);
    #1 dv7 = 1'b0;
    @(negedge clk);
    ln_e = '0; ln_o = '0; dn_e = '0;
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      ln_e[i] = serial_e; ln_o[i] = serial_o; dn_e[i] = done_e;
    end
    check("even_line", ln_e, sb7.pop_front());
    check("odd_line", ln_o, sb7.pop_front());
    check("even_done", dn_e, 64'd1 << 43);
    @(negedge clk);
    check("even_active_end", 64'(active_e), 64'(0));

    // Fill past full: sixth push dropped, five frames back-to-back
    gaps.delete();
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i), i < 5);
    @(negedge clk);
    check("count_peak", 64'(count), 64'(4));
    check("ready_full", 64'(ready), 64'(0));
    wait_idle(1000);
    check("done_pulses", 64'(done_cnt - d0), 64'(5));
    check("frames5", 64'(gaps.size()), 64'(5));
    if (gaps.size() == 5)
      for (int i = 1; i < 5; i++) check("gap_b2b", 64'(gaps[i]), 64'(0));

    // Push coinciding with the end-of-stop pop
    gaps.delete();
    push(8'hC3, 1'b1); push(8'h5A, 1'b1); push(8'h81, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 200);
    check("sync_done", 64'(n < 200), 64'(1));
    check("count_before", 64'(count), 64'(2));
    check("ready_before", 64'(ready), 64'(1));
    dv = 1'b1; tx_word = 8'h3C; sb.push_back(8'h3C);
    @(posedge clk);
    #1 dv = 1'b0;
    @(negedge clk);
    check("count_same", 64'(count), 64'(2));
    wait_idle(1000);
    check("frames4", 64'(gaps.size()), 64'(4));
    if (gaps.size() == 4)
      for (int i = 1; i < 4; i++) check("gap_pushpop", 64'(gaps[i]), 64'(0));

    // Input word changes after acceptance must not affect the frame
    push(8'hA5, 1'b1);
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      tx_word = 8'($urandom);
    end
    wait_idle(200);

    // Reset during data bit 3 with two words queued
    push(8'h11, 1'b1); push(8'h22, 1'b1); push(8'h33, 1'b1);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("count_q2", 64'(count), 64'(2));
    check("mid_active", 64'(active), 64'(1));
    rst_n = 1'b0;
    sb.delete();
    d0 = done_cnt;
    @(negedge clk);
    check("mid_rst_serial", 64'(serial), 64'(1));
    check("mid_rst_active", 64'(active), 64'(0));
    check("mid_rst_count", 64'(count), 64'(0));
    check("mid_rst_ready", 64'(ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    low = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (serial !== 1'b1) low = 1'b1;
    end
    check("line_high_after", 64'(low), 64'(0));
    check("no_done_after", 64'(done_cnt - d0), 64'(0));
    check("count_after", 64'(count), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
